// File: rtl/circuit_2_pkg.sv
// Shared encodings for the Circuit_2 scheduler: FSM states and datapath widths.
package circuit_2_pkg;

  localparam int RES_W = 3;
  localparam int VEC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/Circuit_2.sv
// Shared combinational Circuit_2 datapath: three boolean functions of A..D.
module Circuit_2 (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic Out_1,
  output logic Out_2,
  output logic Out_3
);

  assign Out_1 = (C & ~D) | A;
  assign Out_2 = B ^ D;
  assign Out_3 = ~(B & C & D);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req at or after ptr, wrapping, as one-hot plus index.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  int cand;

  // NOTE: every output gets a default before the search loop so no path leaves a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/circuit_2_sched.sv
// Round-robin scheduler sharing one Circuit_2 among NREQ requesters (IDLE->EVAL->RESP).
// Optional evaluation counter enabled by defining CIRCUIT_2_CNT_EN.
module circuit_2_sched
  import circuit_2_pkg::*;
#(
  parameter int NREQ = 4
`ifdef CIRCUIT_2_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [VEC_W*NREQ-1:0] vec,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [RES_W-1:0]      result
`ifdef CIRCUIT_2_CNT_EN
  , output logic [CNT_W-1:0]    eval_cnt
`endif
);

  localparam int PTR_W = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [VEC_W-1:0]   abcd_q, abcd_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               out_1, out_2, out_3;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  Circuit_2 u_c2 (abcd_q[3], abcd_q[2], abcd_q[1], abcd_q[0], out_1, out_2, out_3);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    abcd_d   = abcd_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          abcd_d  = vec[int'(arb_idx)*VEC_W +: VEC_W];
          gnt_d   = arb_gnt;
          win_d   = arb_idx;
          busy_d  = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        result_d = {out_1, out_2, out_3};
        done_d   = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        // The winner drops to lowest priority for the next arbitration.
        ptr_d   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
        done_d  = 1'b0;
        busy_d  = 1'b0;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      abcd_q   <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      abcd_q   <= abcd_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

`ifdef CIRCUIT_2_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (done_q) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign eval_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_circuit_2_sched.sv
// Directed bench for circuit_2_sched; counter scenario runs when CIRCUIT_2_CNT_EN is defined.
module tb_circuit_2_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] vec;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [2:0]  result;
`ifdef CIRCUIT_2_CNT_EN
  logic [1:0]  eval_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

`ifdef CIRCUIT_2_CNT_EN
  circuit_2_sched #(.NREQ(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .vec(vec), .gnt(gnt),
    .busy(busy), .done(done), .result(result), .eval_cnt(eval_cnt)
  );
`else
  circuit_2_sched #(.NREQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .vec(vec), .gnt(gnt),
    .busy(busy), .done(done), .result(result)
  );
`endif

  // Golden Circuit_2: {Out_1,Out_2,Out_3} from {A,B,C,D}.
  function automatic logic [2:0] model(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {(c & ~d) | a, b ^ d, ~(b & c & d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; vec = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || result !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got gnt=%b busy=%b done=%b result=%b want 0000/0/0/000",
                 i, gnt, busy, done, result);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0001; vec = 16'h0005;
    tick();
    vectors++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_accept: got gnt=%b busy=%b done=%b want 0001/1/0", gnt, busy, done);
    end
    req = '0;
    tick();
    vectors++;
    if (done !== 1'b1 || result !== model(4'b0101) || gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_done: got done=%b result=%b gnt=%b want 1/%b/0001",
               done, result, gnt, model(4'b0101));
    end
    tick();
    vectors++;
    if (done !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || result !== model(4'b0101)) begin
      miscompares++;
      $display("FAIL single_after: got done=%b gnt=%b busy=%b result=%b want 0/0000/0/%b",
               done, gnt, busy, result, model(4'b0101));
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] vecs    [4] = '{4'b0101, 4'b0110, 4'b0111, 4'b0110};
    int w;
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    vec = {vecs[3], vecs[2], vecs[1], vecs[0]};
    for (int t = 0; t < 5; t++) begin
      w = t % 4;
      tick();
      vectors++;
      if (gnt !== exp_gnt[t] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rotate_gnt[%0d]: got gnt=%b busy=%b want %b/1", t, gnt, busy, exp_gnt[t]);
      end
      tick();
      vectors++;
      if (done !== 1'b1 || result !== model(vecs[w])) begin
        miscompares++;
        $display("FAIL rotate_done[%0d]: got done=%b result=%b want 1/%b", t, done, result, model(vecs[w]));
      end
      tick();
      vectors++;
      if (done !== 1'b0 || gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL rotate_gap[%0d]: got done=%b gnt=%b want 0/0000", t, done, gnt);
      end
    end
    req = '0;
  endtask

  task automatic test_latch();
    req = 4'b0100; vec = 16'h0600;
    tick();
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL latch_gnt: got %b want 0100", gnt);
    end
    vec = 16'hFFFF; req = '0;
    tick();
    vectors++;
    if (done !== 1'b1 || result !== model(4'b0110)) begin
      miscompares++;
      $display("FAIL latch_done: got done=%b result=%b want 1/%b", done, result, model(4'b0110));
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || result !== model(4'b0110)) begin
        miscompares++;
        $display("FAIL latch_hold[%0d]: got gnt=%b busy=%b done=%b result=%b want 0000/0/0/%b",
                 i, gnt, busy, done, result, model(4'b0110));
      end
    end
  endtask

  task automatic test_reset_inflight();
    // Lone requester 0 wins despite the pointer sitting at 3; pointer then moves to 1.
    req = 4'b0001; vec = 16'h0005;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL lone_gnt: got %b want 0001", gnt);
    end
    req = '0;
    tick(); tick();
    req = 4'b0010; vec = 16'h0070;
    tick();
    vectors++;
    if (gnt !== 4'b0010 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_accept: got gnt=%b busy=%b want 0010/1", gnt, busy);
    end
    reset = 1'b1; req = '0;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || result !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_reset: got gnt=%b busy=%b done=%b result=%b want 0000/0/0/000",
               gnt, busy, done, result);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (done !== 1'b0 || result !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_nodone: got done=%b result=%b want 0/000", done, result);
    end
    req = 4'b0011;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL abort_ptr: got gnt=%b want 0001", gnt);
    end
    req = '0;
    tick();
    vectors++;
    if (done !== 1'b1 || result !== model(4'b0000)) begin
      miscompares++;
      $display("FAIL abort_next_done: got done=%b result=%b want 1/%b", done, result, model(4'b0000));
    end
    tick();
  endtask

`ifdef CIRCUIT_2_CNT_EN
  task automatic test_eval_cnt();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0;
    vectors++;
    if (eval_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL cnt_reset: got %0d want 0", eval_cnt);
    end
    for (int t = 0; t < 5; t++) begin
      req = 4'b0001; vec = 16'h0005;
      tick();
      req = '0;
      tick(); tick();
      vectors++;
      if (eval_cnt !== exp_cnt[t]) begin
        miscompares++;
        $display("FAIL cnt[%0d]: got %0d want %0d", t, eval_cnt, exp_cnt[t]);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_latch();
    test_reset_inflight();
`ifdef CIRCUIT_2_CNT_EN
    test_eval_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
